aes128_iter_core: RTL and testbench

- Iterative, registered AES-128 encryption engine built from the existing sbox, shift_rows, mix_col and key_scheduler blocks.
- Executes one AES round per clock, with the round key expanded on the fly, so a full block completes in NR+1 cycles.
- Uses valid/ready handshakes on input and output, so it drops into a streaming datapath as the block-cipher stage.
- Unlike the combinational single-round datapath, it:
  - sequences all rounds internally,
  - omits MixColumns in the final round,
  - supports a reduced round count for characterisation.

---
 rtl/aes128_iter_core.sv | 195 +++++++++++++++++++
 tb/tb_aes128_iter_core.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_core.sv
// aes128_iter_core
// Iterative AES-128 encryption engine. It runs one cipher round per clock and
// expands the round key on the fly. A block needs NR+1 cycles counting the
// accept edge. Both sides use valid/ready handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   plaintext/key pair offered
//   in_ready   core can accept a pair this cycle
//   in_data    plaintext block [0:127], byte 0 = bits [0:7]
//   in_key     cipher key [0:127], same ordering
//   out_valid  ciphertext available (held until out_ready)
//   out_ready  downstream accepts ciphertext
//   out_data   ciphertext block [0:127]
//   busy       high while rounds are executing
//   round_idx  round executed on the next edge, 0 when not running
module aes128_iter_core #(
  parameter int NR     = 10,
  parameter int RIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:127]      in_data,
  input  logic [0:127]      in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:127]      out_data,
  output logic              busy,
  output logic [RIDX_W-1:0] round_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, next_state;
  logic [0:127] state_reg, rkey_reg, result;
  logic [0:127] sb_sr, rk, mid_round, final_round;
  logic         last_round, accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box computed arithmetically: multiplicative inverse as x^254 built from
  // x^2 * x^4 * ... * x^128, followed by the AES affine transform. Zero maps
  // to zero before the affine step, which yields the required 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, inv;
    p   = gf_mul(x, x);
    inv = p;
    for (int i = 0; i < 6; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:127] sub_bytes(input logic [0:127] x);
    logic [0:127] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = sbox(x[8*i +: 8]);
    return y;
  endfunction

  // State is column-major: byte index = 4*column + row. Row r rotates left by r.
  function automatic logic [0:127] shift_rows(input logic [0:127] x);
    logic [0:127] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[8*(4*c+r) +: 8] = x[8*(4*((c+r)%4)+r) +: 8];
    return y;
  endfunction

  function automatic logic [0:127] mix_col(input logic [0:127] x);
    logic [0:127] y;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = x[32*c +: 8];
      a1 = x[32*c+8 +: 8];
      a2 = x[32*c+16 +: 8];
      a3 = x[32*c+24 +: 8];
      y[32*c    +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      y[32*c+8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      y[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      y[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return y;
  endfunction

  // Round constant for round idx: 0x01 doubled (idx-1) times in GF(2^8).
  function automatic logic [7:0] rcon(input logic [RIDX_W-1:0] idx);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 2; i < (1 << RIDX_W); i++)
      if (i <= int'(idx)) r = xtime(r);
    return r;
  endfunction

  // Derives the key for round idx from the previous round key.
  function automatic logic [0:127] key_scheduler(input logic [RIDX_W-1:0] idx,
                                                 input logic [0:127] k);
    logic [31:0]  w0, w1, w2, w3, rot, temp;
    logic [0:127] y;
    w0   = k[0  +: 32];
    w1   = k[32 +: 32];
    w2   = k[64 +: 32];
    w3   = k[96 +: 32];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]) ^ rcon(idx), sbox(rot[23:16]),
            sbox(rot[15:8]), sbox(rot[7:0])};
    y[0  +: 32] = w0 ^ temp;
    y[32 +: 32] = w1 ^ w0 ^ temp;
    y[64 +: 32] = w2 ^ w1 ^ w0 ^ temp;
    y[96 +: 32] = w3 ^ w2 ^ w1 ^ w0 ^ temp;
    return y;
  endfunction

  assign sb_sr       = shift_rows(sub_bytes(state_reg));
  assign rk          = key_scheduler(round_idx, rkey_reg);
  assign mid_round   = mix_col(sb_sr) ^ rk;
  assign final_round = sb_sr ^ rk;
  assign last_round  = (round_idx == RIDX_W'(NR));
  assign accept      = in_valid & in_ready;
  assign out_data    = result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // In DONE, a new pair may be accepted on the same edge that retires the
  // output, so a streaming source sees no bubble between blocks.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = RUN;
      RUN:     if (last_round) next_state = DONE;
      DONE:    if (out_ready) next_state = in_valid ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      RUN:     busy = 1'b1;
      DONE:    begin
                 in_ready  = out_ready;
                 out_valid = 1'b1;
               end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath registers. result is written only by the final round, so
  // out_data holds the last ciphertext after retirement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      rkey_reg  <= '0;
      result    <= '0;
      round_idx <= '0;
    end else if (accept) begin
      state_reg <= in_data ^ in_key;
      rkey_reg  <= in_key;
      round_idx <= RIDX_W'(1);
    end else if (state == RUN) begin
      rkey_reg <= rk;
      if (last_round) begin
        result    <= final_round;
        round_idx <= '0;
      end else begin
        state_reg <= mid_round;
        round_idx <= round_idx + RIDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aes128_iter_core.sv
// tb_aes128_iter_core
// Directed bench for aes128_iter_core. It covers reset values, the FIPS-197
// vectors, an internal round-1 probe, backpressure, back-to-back blocks,
// ignored input during RUN and a reset in the middle of a run.
module tb_aes128_iter_core;

  localparam int NR     = 10;
  localparam int RIDX_W = 4;

  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [0:127]      in_data;
  logic [0:127]      in_key;
  logic              out_valid;
  logic              out_ready;
  logic [0:127]      out_data;
  logic              busy;
  logic [RIDX_W-1:0] round_idx;

  int checks = 0;
  int errors = 0;
  int n;

  aes128_iter_core #(.NR(NR), .RIDX_W(RIDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round_idx (round_idx)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idx(input string tag, input logic [RIDX_W-1:0] obs,
                           input logic [RIDX_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [127:0] obs,
                            input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %032h expected %032h", tag, obs, exp);
    end
  endtask

  // Offers one pair for a single cycle; returns just after the accept edge.
  task automatic apply_stimulus(input logic [127:0] d, input logic [127:0] k);
    in_data  = d;
    in_key   = k;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges (accept edge already counted as start) until out_valid, bounded.
  task automatic wait_done(input int start, output int cycles);
    cycles = start;
    while (out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b1;
    #1;
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_idx("reset_round_idx", round_idx, '0);
    check_word("reset_out_data", out_data, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] FIPS-197 App. B vector");
    apply_stimulus(B_PT, B_KEY);
    check_bit("b_busy", busy, 1'b1);
    check_bit("b_in_ready_run", in_ready, 1'b0);
    check_idx("b_round_idx_1", round_idx, RIDX_W'(1));
    @(posedge clk);
    #1;
    check_word("b_round1_state", dut.state_reg, B_R1);
    check_idx("b_round_idx_2", round_idx, RIDX_W'(2));
    wait_done(2, n);
    check_bit("b_latency", n == NR + 1, 1'b1);
    check_word("b_ciphertext", out_data, B_CT);
    check_bit("b_in_ready_done", in_ready, 1'b1);
    check_idx("b_round_idx_done", round_idx, '0);
    @(posedge clk);
    #1;
    check_bit("b_retire", out_valid, 1'b0);

    $display("[TB] FIPS-197 App. C.1 vector");
    apply_stimulus(C_PT, C_KEY);
    wait_done(1, n);
    check_bit("c_latency", n == NR + 1, 1'b1);
    check_word("c_ciphertext", out_data, C_CT);
    @(posedge clk);
    #1;
    check_word("c_data_kept", out_data, C_CT);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    apply_stimulus(B_PT, B_KEY);
    wait_done(1, n);
    check_bit("bp_latency", n == NR + 1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check_bit("bp_out_valid", out_valid, 1'b1);
      check_word("bp_out_data", out_data, B_CT);
      check_bit("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check_bit("bp_in_ready_comb", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check_bit("bp_retired", out_valid, 1'b0);
    check_bit("bp_idle_ready", in_ready, 1'b1);

    $display("[TB] back-to-back");
    in_data  = B_PT;
    in_key   = B_KEY;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = C_PT;
    in_key  = C_KEY;
    check_bit("b2b_in_ready_run", in_ready, 1'b0);
    wait_done(1, n);
    check_bit("b2b_first_latency", n == NR + 1, 1'b1);
    check_word("b2b_first_ct", out_data, B_CT);
    check_bit("b2b_in_ready_pulse", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_bit("b2b_second_busy", busy, 1'b1);
    check_bit("b2b_out_valid_low", out_valid, 1'b0);
    wait_done(1, n);
    check_bit("b2b_second_spacing", n == NR + 1, 1'b1);
    check_word("b2b_second_ct", out_data, C_CT);
    @(posedge clk);
    #1;
    check_bit("b2b_retire", out_valid, 1'b0);

    $display("[TB] ignored input during RUN");
    apply_stimulus(C_PT, C_KEY);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = 1'b0;
    wait_done(6, n);
    check_bit("ign_latency", n == NR + 1, 1'b1);
    check_word("ign_ciphertext", out_data, C_CT);
    @(posedge clk);
    #1;

    $display("[TB] reset mid-run");
    apply_stimulus(B_PT, B_KEY);
    repeat (4) @(posedge clk);
    #1;
    check_idx("rst_at_round5", round_idx, RIDX_W'(5));
    rst = 1'b1;
    #1;
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_idx("rst_round_idx", round_idx, '0);
    check_word("rst_out_data", out_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(B_PT, B_KEY);
    wait_done(1, n);
    check_bit("rst_fresh_latency", n == NR + 1, 1'b1);
    check_word("rst_fresh_ct", out_data, B_CT);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
